// File: rtl/bp_cfg_boot_pkg.sv
// Shared types and helpers for the config-bus boot sequencer.
package bp_cfg_boot_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_send,
    e_wait,
    e_adv,
    e_done,
    e_error
  } bp_cfg_boot_state_e;

  localparam logic [15:0] bp_cfg_freeze_addr_gp   = 16'h0001;
  localparam logic [15:0] bp_cfg_core_id_addr_gp  = 16'h0002;
  localparam logic [15:0] bp_cfg_cord_addr_gp     = 16'h0003;
  localparam logic [15:0] bp_cfg_cce_mode_addr_gp = 16'h0004;

  // core is 8 bits so it can double as the sequencer's core index (N <= 256)
  typedef struct packed {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
  } bp_cfg_write_s;

  function automatic bp_cfg_write_s bp_cfg_make_write(input logic       unfreeze,
                                                      input logic [1:0] sel,
                                                      input logic [7:0] idx,
                                                      input logic [7:0] x,
                                                      input logic [7:0] y,
                                                      input logic       cce_mode);
    bp_cfg_write_s w;
    w.core = idx;
    w.addr = bp_cfg_freeze_addr_gp;
    w.data = '0;
    if (!unfreeze) begin
      case (sel)
        2'd0: w.data = 64'd1;
        2'd1: begin
          w.addr = bp_cfg_core_id_addr_gp;
          w.data = {56'd0, idx};
        end
        2'd2: begin
          w.addr = bp_cfg_cord_addr_gp;
          w.data = {48'd0, y, x};
        end
        default: begin
          w.addr = bp_cfg_cce_mode_addr_gp;
          w.data = {63'd0, cce_mode};
        end
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/bp_cfg_boot_sequencer_if.sv
// Config-bus write channel plus ack return between the sequencer and tile endpoints.
interface bp_cfg_boot_sequencer_if #(
  parameter int core_width_p = 2,
  parameter int addr_width_p = 16,
  parameter int data_width_p = 64
);
  logic                    cfg_v;
  logic                    cfg_ready_and;
  logic [core_width_p-1:0] cfg_core;
  logic [addr_width_p-1:0] cfg_addr;
  logic [data_width_p-1:0] cfg_data;
  logic                    cfg_ack_v;
  logic                    cfg_ack_err;

  modport master (
    output cfg_v, cfg_core, cfg_addr, cfg_data,
    input  cfg_ready_and, cfg_ack_v, cfg_ack_err
  );

  modport slave (
    input  cfg_v, cfg_core, cfg_addr, cfg_data,
    output cfg_ready_and, cfg_ack_v, cfg_ack_err
  );
endinterface

// File: rtl/bp_cfg_boot_timeout.sv
// Saturating ack-wait counter; expired_o holds once the count reaches limit_p-1.
module bp_cfg_boot_timeout #(
  parameter  int limit_p  = 1024,
  localparam int width_lp = (limit_p > 1) ? $clog2(limit_p) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [width_lp-1:0] count_q, count_d;

  assign expired_o = (count_q == width_lp'(limit_p - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot sequencer: per core FREEZE/CORE_ID/CORD/CCE_MODE writes, then unfreeze all cores.
// state   | meaning
// e_idle  | quiescent, waiting for start_i
// e_send  | write valid, held until ready
// e_wait  | write accepted, waiting for ack or timeout
// e_adv   | step to the next write or finish
// e_done  | all writes acked, done_o sticky
// e_error | aborted on ack error or timeout, err_o sticky
module bp_cfg_boot_sequencer
  import bp_cfg_boot_pkg::*;
#(
  parameter  int cc_x_dim_p       = 2,
  parameter  int cc_y_dim_p       = 2,
  parameter  int cfg_addr_width_p = 16,
  parameter  int cfg_data_width_p = 64,
  parameter  int ack_timeout_p    = 1024,
  localparam int num_core_lp      = cc_x_dim_p * cc_y_dim_p,
  localparam int core_width_lp    = (num_core_lp > 1) ? $clog2(num_core_lp) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     cce_mode_i,
  bp_cfg_boot_sequencer_if.master  cfg,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [core_width_lp-1:0] err_core_o
);

  bp_cfg_boot_state_e       state_q;
  bp_cfg_write_s            wr_q, wr_d;
  logic [7:0]               idx_d;
  logic [1:0]               reg_q, reg_d;
  logic                     phase_q, phase_d;
  logic [7:0]               x_q, x_d, y_q, y_d;
  logic                     cce_mode_q;
  logic                     cfg_v_q, busy_q, done_q, err_q;
  logic [core_width_lp-1:0] err_core_q;
  logic                     last_core, handshake, expired;

  assign last_core = (wr_q.core == 8'(num_core_lp - 1));
  assign handshake = (state_q == e_send) && cfg.cfg_ready_and;

  bp_cfg_boot_timeout #(.limit_p(ack_timeout_p)) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (handshake),
    .en_i     (state_q == e_wait),
    .expired_o(expired)
  );

  // Next write pointers; x/y step alongside the index so no divider is needed.
  always_comb begin
    idx_d   = wr_q.core;
    reg_d   = reg_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    if (!phase_q) begin
      reg_d = reg_q + 2'd1;
      if (reg_q == 2'd3) begin
        if (last_core) begin
          phase_d = 1'b1;
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          idx_d = wr_q.core + 8'd1;
          if (x_q == 8'(cc_x_dim_p - 1)) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
    end else begin
      idx_d = wr_q.core + 8'd1;
    end
    wr_d = bp_cfg_make_write(phase_d, reg_d, idx_d, x_d, y_d, cce_mode_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_idle;
      wr_q       <= '0;
      reg_q      <= '0;
      phase_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      cce_mode_q <= 1'b0;
      cfg_v_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_core_q <= '0;
    end else begin
      case (state_q)
        e_idle, e_done, e_error: begin
          if (start_i) begin
            state_q    <= e_send;
            wr_q       <= bp_cfg_make_write(1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
            reg_q      <= '0;
            phase_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cce_mode_q <= cce_mode_i;
            cfg_v_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_core_q <= '0;
          end
        end
        e_send: begin
          if (cfg.cfg_ready_and) begin
            state_q <= e_wait;
            cfg_v_q <= 1'b0;
          end
        end
        e_wait: begin
          // A good ack takes priority over a timeout expiring in the same cycle.
          if (cfg.cfg_ack_v && !cfg.cfg_ack_err) begin
            state_q <= e_adv;
          end else if (cfg.cfg_ack_v || expired) begin
            state_q    <= e_error;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_core_q <= wr_q.core[core_width_lp-1:0];
          end
        end
        e_adv: begin
          if (phase_q && last_core) begin
            state_q <= e_done;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= e_send;
            wr_q    <= wr_d;
            reg_q   <= reg_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cfg_v_q <= 1'b1;
          end
        end
        default: state_q <= e_idle;
      endcase
    end
  end

  assign cfg.cfg_v    = cfg_v_q;
  assign cfg.cfg_core = wr_q.core[core_width_lp-1:0];
  assign cfg.cfg_addr = cfg_addr_width_p'(wr_q.addr);
  assign cfg.cfg_data = cfg_data_width_p'(wr_q.data);
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_core_o   = err_core_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Directed bench: a 1x1 instance and a 2x2 instance (ack timeout 8) with a write scoreboard.
module tb_bp_cfg_boot_sequencer;

  typedef struct packed {
    logic [63:0] core;
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  logic       clk, rst;
  logic       start1, mode1, busy1, done1, err1;
  logic [0:0] ecore1;
  logic       start2, mode2, busy2, done2, err2;
  logic [1:0] ecore2;

  exp_t q1[$];
  exp_t q2[$];

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int v_cycles = 0;
  int wcnt = 0;
  int hold_n = -1;
  int err_n = -1;
  int ack_delay = 0;
  int hs_cyc = 0;
  int ack_wait = 0;
  bit ack_err_pend = 0;
  bit ack1_pend = 0;
  bit bp_en = 0;
  bit stall_prev = 0;
  logic [63:0] pcore, paddr, pdata;

  bp_cfg_boot_sequencer_if #(.core_width_p(1)) if1 ();
  bp_cfg_boot_sequencer_if #(.core_width_p(2)) if2 ();

  bp_cfg_boot_sequencer #(.cc_x_dim_p(1), .cc_y_dim_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start1), .cce_mode_i(mode1), .cfg(if1),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .err_core_o(ecore1)
  );

  bp_cfg_boot_sequencer #(.cc_x_dim_p(2), .cc_y_dim_p(2), .ack_timeout_p(8)) u_dut2 (
    .clk_i(clk), .reset_i(rst), .start_i(start2), .cce_mode_i(mode2), .cfg(if2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .err_core_o(ecore2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference write list; coordinates use mod/div of the index.
  task automatic push_seq(input int xd, input int yd, input bit mode, input bit which,
                          input int limit);
    int   n = xd * yd;
    int   k = 0;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < 4; r++) begin
        e.core = 64'(i);
        case (r)
          0: begin e.addr = 64'h1; e.data = 64'd1; end
          1: begin e.addr = 64'h2; e.data = 64'(i); end
          2: begin e.addr = 64'h3; e.data = 64'(((i / xd) << 8) | (i % xd)); end
          default: begin e.addr = 64'h4; e.data = 64'(mode); end
        endcase
        if (k < limit) begin
          if (which) q2.push_back(e); else q1.push_back(e);
        end
        k++;
      end
    end
    for (int i = 0; i < n; i++) begin
      e.core = 64'(i);
      e.addr = 64'h1;
      e.data = 64'd0;
      if (k < limit) begin
        if (which) q2.push_back(e); else q1.push_back(e);
      end
      k++;
    end
  endtask

  task automatic pulse2();
    wcnt = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic wait_flag(input int sel, input int budget, input string tag);
    int n = 0;
    while (!((sel == 0) ? done1 : (sel == 1) ? done2 : err2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  // 1x1 endpoint: always ready, acks one cycle after each write.
  initial begin
    exp_t e;
    if1.cfg_ready_and = 1'b1;
    if1.cfg_ack_v     = 1'b0;
    if1.cfg_ack_err   = 1'b0;
    forever begin
      @(negedge clk);
      if1.cfg_ack_v = ack1_pend;
      ack1_pend     = 1'b0;
      if (if1.cfg_v) begin
        if (q1.size() > 0) e = q1.pop_front(); else e = '1;
        chk("w1_core", 64'(if1.cfg_core), e.core);
        chk("w1_addr", 64'(if1.cfg_addr), e.addr);
        chk("w1_data", if1.cfg_data, e.data);
        ack1_pend = 1'b1;
      end
    end
  end

  // 2x2 endpoint: optional backpressure, withheld/err/delayed acks by write number.
  initial begin
    exp_t e;
    if2.cfg_ready_and = 1'b0;
    if2.cfg_ack_v     = 1'b0;
    if2.cfg_ack_err   = 1'b0;
    forever begin
      @(negedge clk);
      if2.cfg_ack_v   = 1'b0;
      if2.cfg_ack_err = 1'b0;
      if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) begin
          if2.cfg_ack_v   = 1'b1;
          if2.cfg_ack_err = ack_err_pend;
        end
      end
      if (if2.cfg_v) v_cycles++;
      if (if2.cfg_v && stall_prev) begin
        chk("stall_core", 64'(if2.cfg_core), pcore);
        chk("stall_addr", 64'(if2.cfg_addr), paddr);
        chk("stall_data", if2.cfg_data, pdata);
      end
      if2.cfg_ready_and = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (if2.cfg_v && if2.cfg_ready_and) begin
        if (q2.size() > 0) e = q2.pop_front(); else e = '1;
        chk("w2_core", 64'(if2.cfg_core), e.core);
        chk("w2_addr", 64'(if2.cfg_addr), e.addr);
        chk("w2_data", if2.cfg_data, e.data);
        hs_cyc = cyc + 1;
        if (wcnt != hold_n) begin
          ack_wait     = ack_delay + 1;
          ack_err_pend = (wcnt == err_n);
        end
        wcnt++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = if2.cfg_v;
        pcore      = 64'(if2.cfg_core);
        paddr      = 64'(if2.cfg_addr);
        pdata      = if2.cfg_data;
      end
    end
  end

  initial begin
    int vc;
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    mode1  = 1'b0;
    mode2  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_v2", 64'(if2.cfg_v), 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    chk("rst_done2", 64'(done2), 64'd0);
    chk("rst_err2", 64'(err2), 64'd0);
    chk("rst_ecore2", 64'(ecore2), 64'd0);
    chk("rst_addr2", 64'(if2.cfg_addr), 64'd0);
    chk("rst_data2", if2.cfg_data, 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    rst = 1'b0;

    // 1x1, cce mode 1
    push_seq(1, 1, 1'b1, 1'b0, 1000);
    mode1 = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_flag(0, 100, "a_done");
    chk("a_busy", 64'(busy1), 64'd0);
    chk("a_err", 64'(err1), 64'd0);
    chk("a_left", 64'(q1.size()), 64'd0);

    // 2x2, cce mode 0, always ready
    push_seq(2, 2, 1'b0, 1'b1, 1000);
    pulse2();
    wait_flag(1, 300, "b_done");
    chk("b_busy", 64'(busy2), 64'd0);
    chk("b_err", 64'(err2), 64'd0);
    chk("b_left", 64'(q2.size()), 64'd0);

    // backpressure, restart from DONE, start while busy ignored
    bp_en = 1'b1;
    push_seq(2, 2, 1'b0, 1'b1, 1000);
    pulse2();
    chk("c_done_clr", 64'(done2), 64'd0);
    chk("c_busy", 64'(busy2), 64'd1);
    repeat (5) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("c_busy_mid", 64'(busy2), 64'd1);
    wait_flag(1, 800, "c_done");
    chk("c_left", 64'(q2.size()), 64'd0);
    bp_en = 1'b0;

    // ack withheld on core 1 CORE_ID (write 5) -> timeout
    hold_n = 5;
    push_seq(2, 2, 1'b0, 1'b1, 6);
    pulse2();
    wait_flag(2, 300, "d_err");
    chk("d_latency", 64'(cyc - hs_cyc), 64'd8);
    chk("d_ecore", 64'(ecore2), 64'd1);
    chk("d_done", 64'(done2), 64'd0);
    vc = v_cycles;
    repeat (20) @(negedge clk);
    chk("d_no_valid", 64'(v_cycles - vc), 64'd0);
    chk("d_left", 64'(q2.size()), 64'd0);

    // rerun from ERROR
    hold_n = -1;
    push_seq(2, 2, 1'b1, 1'b1, 1000);
    mode2 = 1'b1;
    pulse2();
    chk("e_err_clr", 64'(err2), 64'd0);
    wait_flag(1, 300, "e_done");
    chk("e_left", 64'(q2.size()), 64'd0);

    // error ack on core 2 CCE_MODE (write 11)
    err_n = 11;
    push_seq(2, 2, 1'b1, 1'b1, 12);
    pulse2();
    wait_flag(2, 300, "f_err");
    chk("f_ecore", 64'(ecore2), 64'd2);
    chk("f_left", 64'(q2.size()), 64'd0);

    // every ack lands in the timeout cycle -> still good
    err_n     = -1;
    ack_delay = 7;
    push_seq(2, 2, 1'b1, 1'b1, 1000);
    pulse2();
    wait_flag(1, 600, "g_done");
    chk("g_err", 64'(err2), 64'd0);
    chk("g_left", 64'(q2.size()), 64'd0);
    ack_delay = 0;

    // async reset in the middle of WAIT
    hold_n = 0;
    push_seq(2, 2, 1'b1, 1'b1, 1);
    pulse2();
    @(negedge clk);
    @(negedge clk);
    chk("h_wait_v", 64'(if2.cfg_v), 64'd0);
    chk("h_wait_busy", 64'(busy2), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("h_rst_busy2", 64'(busy2), 64'd0);
    chk("h_rst_addr2", 64'(if2.cfg_addr), 64'd0);
    chk("h_rst_data2", if2.cfg_data, 64'd0);
    chk("h_rst_core2", 64'(if2.cfg_core), 64'd0);
    chk("h_rst_done1", 64'(done1), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    hold_n = -1;
    chk("h_left", 64'(q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
